hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the ID-stage hazard and interrupt logic of the five-stage MIPS pipeline. Replaces the fixed single-LW / MFC0 stall compares with a per-register countdown scoreboard that supports configurable producer latencies. Adds a multi-cycle HI/LO busy counter and an N-line interrupt sequencer with halt/resume and service states. Sits beside the decoder in ID; its `stall`/`issue` gate the IF/ID and ID/EXE pipeline registers.

## Interface
- `NREG`, 32, architectural register count (power of 2)
- `AW`, 5, register index width, `$clog2(NREG)`
- `LD_LAT`, 2, cycles from issue until a latency-class-1 result (LW) is forwardable; range 1..7
- `C0_LAT`, 3, same for latency class 2 (MFC0); range 1..7
- `MUL_LAT`, 4, cycles HI/LO unit stays busy after issue; range 1..15
- `NINT`, 8, interrupt line count
- `HLT_BIT`, 7, halt request line index
- `RES_BIT`, 6, resume request line index
- `clk`  in  1  clock. Single clock domain; asynchronous, active-high reset `rst` (already decided).
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_rsc`, `id_rtc`  in  AW  source register indices
- `id_rs_rd`, `id_rt_rd`  in  1  instruction reads rs / rt
- `id_rdc`  in  AW  destination index
- `id_rd_we`  in  1  instruction writes `id_rdc`
- `id_lat`  in  2  latency class: 0 short (forwardable next cycle), 1 LD_LAT, 2 C0_LAT, 3 reserved (treated as 0)
- `id_hilo_rd`  in  1  MFHI/MFLO
- `id_hilo_we`  in  1  MULT/MULTU/MTHI/MTLO
- `id_jump`  in  1  branch/jump instruction
- `flush`  in  1  pipeline flush (exception commit / ERET)
- `eret`  in  1  ERET retiring
- `int_sig`, `int_mask`  in  NINT  pending lines, mask
- `cp0_ie`, `cp0_exl`  in  1  global enable, exception level
- `stall`  out  1  hold IF/ID, bubble into EXE
- `issue`  out  1  ID instruction advances this cycle
- `hilo_busy`  out  1  HI/LO counter nonzero
- `branch_delay`  out  1  instruction now in EXE was an issued jump
- `ex_req`  out  1  take exception this cycle
- `ex_code`  out  5  0 INT, 1 HLT, 2 RESUME
- `ex_line`  out  `$clog2(NINT)`  line index of accepted interrupt
- `halted`  out  1  sequencer in HALT

## Operation
- Scoreboard: `cnt[r]`, 3 bits, per register. On `issue & id_rd_we & id_rdc!=0`:
  - `cnt[id_rdc] <=` LD_LAT-1 (class 1), C0_LAT-1 (class 2), or 0 (short; a newer producer wins forwarding).
  - Every other nonzero counter decrements by 1 each cycle.
  - A set on the same register as a decrement takes priority.
  - `cnt[0]` is always 0.
- `dep_stall = id_valid & ((id_rs_rd & cnt[id_rsc]!=0) | (id_rt_rd & cnt[id_rtc]!=0))`
- HI/LO:
  - `issue & id_hilo_we` loads `hilo_cnt <= MUL_LAT-1`; otherwise decrement while nonzero.
  - `hilo_stall = id_valid & (id_hilo_rd | id_hilo_we) & hilo_busy`
- `stall = dep_stall | hilo_stall | halted`
- `issue = id_valid & !stall & !flush & !ex_req`
- `flush` clears all `cnt` and `hilo_cnt` at the next edge; flush beats a same-cycle set.
- `branch_delay <= issue & id_jump`. It clears on flush.
- Interrupt sequencer states:
  - RUN
    - `cp0_ie & !cp0_exl & int_sig[HLT_BIT] & int_mask[HLT_BIT]`: `ex_req`, code 1, go to HALT.
    - Otherwise, if any other masked pending line (excluding RES_BIT) and `ie & !exl`: `ex_req`, code 0, `ex_line` = lowest such index, go to SVC.
  - SVC
    - No new requests.
    - `eret` goes to RUN.
  - HALT
    - `halted=1`.
    - `cp0_ie & int_sig[RES_BIT] & int_mask[RES_BIT]`: `ex_req`, code 2, go to SVC.
- `ex_req`, `ex_code` and `ex_line` are combinational from state and inputs. `ex_code`/`ex_line` are 0 when `!ex_req`.

## Timing
- Reset: all `cnt`=0, `hilo_cnt`=0, state RUN, `branch_delay`=0, `halted`=0. `ex_req` is forced 0 while `rst`. `stall`/`issue` follow their combinational equations.
- A consumer immediately behind a class-k producer stalls exactly LAT-1 cycles: LD_LAT=2 gives 1 bubble, C0_LAT=3 gives 2.
- A reset deasserting mid-stall resumes from empty scoreboard state.

## Structure
- Package `hazard_pkg`: state enum (RUN/SVC/HALT), `EX_CODE_*` constants, `LAT_*` class codes.
- Sub-module `int_seq`: interrupt sequencer FSM, priority encoder and `ex_*` outputs.
- Scoreboard and HI/LO counter stay in the top module.

## Test plan
- Issue LW to r8 (class 1, LD_LAT=2), next ID `addu` reads r8 -> `stall`=1 for exactly 1 cycle, then `issue`=1.
- MFC0 to r9 (C0_LAT=3) then `sw` reading r9 as rt -> 2 stall cycles. Same sequence with rd=r0 -> 0 stalls.
- LW r8 then short `addu` writing r8, then reader of r8 -> no stall, because the short set clears `cnt[8]`.
- MULT (MUL_LAT=4) then MFLO -> 3 stall cycles. `flush` asserted in the 2nd stall cycle -> `hilo_busy`=0 and `issue` on the following cycle.
- `int_sig`=0x80, mask=0xFF, ie=1, exl=0 -> one-cycle `ex_req`, code 1, then `halted`=1 with `stall` held. Raise `int_sig[6]` -> `ex_req` code 2, state SVC. `eret` -> RUN.
- `int_sig`=0x0A, mask=0x08 -> `ex_line`=3, code 0. No further `ex_req` until `eret`, even with lines still pending.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard and interrupt sequencer.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StSvc  = 2'd1,
      StHalt = 2'd2
   } seq_state_e;

   localparam logic [4:0] EX_CODE_INT = 5'd0;
   localparam logic [4:0] EX_CODE_HLT = 5'd1;
   localparam logic [4:0] EX_CODE_RES = 5'd2;

   localparam logic [1:0] LAT_SHORT = 2'd0;
   localparam logic [1:0] LAT_LD    = 2'd1;
   localparam logic [1:0] LAT_C0    = 2'd2;
   localparam logic [1:0] LAT_RSV   = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_int_seq.sv
// Interrupt sequencer: RUN/SVC/HALT FSM with lowest-index priority encoder.
module int_seq
   import hazard_pkg::*;
#(
   parameter int unsigned NINT    = 8,
   parameter int unsigned HLT_BIT = 7,
   parameter int unsigned RES_BIT = 6,
   localparam int unsigned EXW    = $clog2(NINT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NINT-1:0] int_sig,
   input  logic [NINT-1:0] int_mask,
   input  logic            cp0_ie,
   input  logic            cp0_exl,
   input  logic            eret,
   output logic            ex_req,
   output logic [4:0]      ex_code,
   output logic [EXW-1:0]  ex_line,
   output logic            halted
);

   seq_state_e state_q, state_d;

   logic [NINT-1:0] pend;
   logic            low_found;
   logic [EXW-1:0]  low_idx;
   logic            enabled;
   logic            hlt_pend;
   logic            res_pend;

   // Halt and resume lines never count as ordinary service requests.
   always_comb begin
      pend          = int_sig & int_mask;
      pend[HLT_BIT] = 1'b0;
      pend[RES_BIT] = 1'b0;
   end

   always_comb begin
      low_found = 1'b0;
      low_idx   = '0;
      for (int i = NINT - 1; i >= 0; i--) begin
         if (pend[i]) begin
            low_found = 1'b1;
            low_idx   = EXW'(i);
         end
      end
   end

   assign enabled  = cp0_ie & ~cp0_exl;
   assign hlt_pend = int_sig[HLT_BIT] & int_mask[HLT_BIT];
   assign res_pend = int_sig[RES_BIT] & int_mask[RES_BIT];

   always_comb begin
      state_d = state_q;
      ex_req  = 1'b0;
      ex_code = EX_CODE_INT;
      ex_line = '0;
      unique case (state_q)
         StRun: begin
            if (enabled & hlt_pend) begin
               ex_req  = 1'b1;
               ex_code = EX_CODE_HLT;
               state_d = StHalt;
            end else if (enabled & low_found) begin
               ex_req  = 1'b1;
               ex_code = EX_CODE_INT;
               ex_line = low_idx;
               state_d = StSvc;
            end
         end
         StSvc: begin
            if (eret) state_d = StRun;
         end
         StHalt: begin
            if (cp0_ie & res_pend) begin
               ex_req  = 1'b1;
               ex_code = EX_CODE_RES;
               state_d = StSvc;
            end
         end
         default: state_d = StRun;
      endcase
      if (rst) begin
         ex_req  = 1'b0;
         ex_code = EX_CODE_INT;
         ex_line = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StRun;
      else     state_q <= state_d;
   end

   assign halted = (state_q == StHalt);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register latency countdown, HI/LO busy counter, interrupt gating.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned LD_LAT  = 2,
   parameter int unsigned C0_LAT  = 3,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned NINT    = 8,
   parameter int unsigned HLT_BIT = 7,
   parameter int unsigned RES_BIT = 6,
   localparam int unsigned EXW    = $clog2(NINT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rsc,
   input  logic [AW-1:0]   id_rtc,
   input  logic            id_rs_rd,
   input  logic            id_rt_rd,
   input  logic [AW-1:0]   id_rdc,
   input  logic            id_rd_we,
   input  logic [1:0]      id_lat,
   input  logic            id_hilo_rd,
   input  logic            id_hilo_we,
   input  logic            id_jump,
   input  logic            flush,
   input  logic            eret,
   input  logic [NINT-1:0] int_sig,
   input  logic [NINT-1:0] int_mask,
   input  logic            cp0_ie,
   input  logic            cp0_exl,
   output logic            stall,
   output logic            issue,
   output logic            hilo_busy,
   output logic            branch_delay,
   output logic            ex_req,
   output logic [4:0]      ex_code,
   output logic [EXW-1:0]  ex_line,
   output logic            halted
);

   logic [2:0] cnt_q [NREG];
   logic [2:0] cnt_d [NREG];
   logic [3:0] hilo_q, hilo_d;
   logic [2:0] set_val;
   logic       rd_set;
   logic       dep_stall;
   logic       hilo_stall;

   int_seq #(
      .NINT    (NINT),
      .HLT_BIT (HLT_BIT),
      .RES_BIT (RES_BIT)
   ) u_int_seq (
      .clk      (clk),
      .rst      (rst),
      .int_sig  (int_sig),
      .int_mask (int_mask),
      .cp0_ie   (cp0_ie),
      .cp0_exl  (cp0_exl),
      .eret     (eret),
      .ex_req   (ex_req),
      .ex_code  (ex_code),
      .ex_line  (ex_line),
      .halted   (halted)
   );

   assign dep_stall  = id_valid & ((id_rs_rd & (cnt_q[id_rsc] != 3'd0)) |
                                   (id_rt_rd & (cnt_q[id_rtc] != 3'd0)));
   assign hilo_busy  = (hilo_q != 4'd0);
   assign hilo_stall = id_valid & (id_hilo_rd | id_hilo_we) & hilo_busy;
   assign stall      = dep_stall | hilo_stall | halted;
   assign issue      = id_valid & ~stall & ~flush & ~ex_req;
   assign rd_set     = issue & id_rd_we & (id_rdc != '0);

   always_comb begin
      case (id_lat)
         LAT_LD:  set_val = 3'(LD_LAT - 1);
         LAT_C0:  set_val = 3'(C0_LAT - 1);
         default: set_val = 3'd0;
      endcase
   end

   // A short producer resets the count to 0 so a newer result wins forwarding.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (cnt_q[r] != 3'd0) cnt_d[r] = cnt_q[r] - 3'd1;
         if (rd_set && (id_rdc == AW'(r))) cnt_d[r] = set_val;
         if (flush) cnt_d[r] = 3'd0;
      end
      cnt_d[0] = 3'd0;
   end

   always_comb begin
      hilo_d = hilo_q;
      if (flush)                   hilo_d = 4'd0;
      else if (issue & id_hilo_we) hilo_d = 4'(MUL_LAT - 1);
      else if (hilo_q != 4'd0)     hilo_d = hilo_q - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= 3'd0;
         hilo_q       <= 4'd0;
         branch_delay <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         hilo_q       <= hilo_d;
         branch_delay <= issue & id_jump & ~flush;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against a timestamp-based reference model.
module tb_hazard_scoreboard;

   localparam int unsigned NREG    = 32;
   localparam int unsigned AW      = 5;
   localparam int unsigned LD_LAT  = 2;
   localparam int unsigned C0_LAT  = 3;
   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned NINT    = 8;
   localparam int unsigned HLT_BIT = 7;
   localparam int unsigned RES_BIT = 6;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_rs_rd, id_rt_rd, id_rd_we, id_hilo_rd, id_hilo_we, id_jump;
   logic [AW-1:0] id_rsc, id_rtc, id_rdc;
   logic [1:0] id_lat;
   logic flush, eret, cp0_ie, cp0_exl;
   logic [NINT-1:0] int_sig, int_mask;
   logic stall, issue, hilo_busy, branch_delay, ex_req, halted;
   logic [4:0] ex_code;
   logic [2:0] ex_line;

   hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .LD_LAT(LD_LAT), .C0_LAT(C0_LAT), .MUL_LAT(MUL_LAT),
      .NINT(NINT), .HLT_BIT(HLT_BIT), .RES_BIT(RES_BIT)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rsc(id_rsc), .id_rtc(id_rtc),
      .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_rdc(id_rdc), .id_rd_we(id_rd_we),
      .id_lat(id_lat), .id_hilo_rd(id_hilo_rd), .id_hilo_we(id_hilo_we), .id_jump(id_jump),
      .flush(flush), .eret(eret), .int_sig(int_sig), .int_mask(int_mask), .cp0_ie(cp0_ie),
      .cp0_exl(cp0_exl), .stall(stall), .issue(issue), .hilo_busy(hilo_busy),
      .branch_delay(branch_delay), .ex_req(ex_req), .ex_code(ex_code), .ex_line(ex_line),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // Model: each register records the cycle its value becomes forwardable.
   int unsigned cyc;
   int unsigned ready_at [NREG];
   int unsigned hilo_ready;
   int unsigned m_state;  // 0 run, 1 service, 2 halted
   logic        m_bd;
   int unsigned n_vec, n_err;
   logic o_stall, o_issue, o_hbusy, o_req, o_halt;
   int unsigned o_code, o_line;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      hilo_ready = 0;
      m_state    = 0;
      m_bd       = 1'b0;
   endtask

   task automatic idle();
      id_valid = 0; id_rsc = '0; id_rtc = '0; id_rs_rd = 0; id_rt_rd = 0; id_rdc = '0;
      id_rd_we = 0; id_lat = 2'd0; id_hilo_rd = 0; id_hilo_we = 0; id_jump = 0;
      flush = 0; eret = 0; int_sig = '0; int_mask = '0; cp0_ie = 0; cp0_exl = 0;
   endtask

   task automatic step();
      logic e_dep, e_hbusy, e_hst, e_halt, e_stall, e_issue, e_req, found;
      int unsigned e_code, e_line, low, nxt, lat;
      if (rst) model_reset();
      #2;
      e_dep   = id_valid && ((id_rs_rd && cyc < ready_at[id_rsc]) ||
                             (id_rt_rd && cyc < ready_at[id_rtc]));
      e_hbusy = cyc < hilo_ready;
      e_hst   = id_valid && (id_hilo_rd || id_hilo_we) && e_hbusy;
      e_halt  = (m_state == 2);
      found = 0; low = 0;
      for (int i = 0; i < NINT; i++)
         if (!found && i != HLT_BIT && i != RES_BIT && int_sig[i] && int_mask[i]) begin
            found = 1; low = i;
         end
      e_req = 0; e_code = 0; e_line = 0; nxt = m_state;
      if (m_state == 0 && cp0_ie && !cp0_exl) begin
         if (int_sig[HLT_BIT] && int_mask[HLT_BIT]) begin
            e_req = 1; e_code = 1; nxt = 2;
         end else if (found) begin
            e_req = 1; e_code = 0; e_line = low; nxt = 1;
         end
      end else if (m_state == 1 && eret) begin
         nxt = 0;
      end else if (m_state == 2 && cp0_ie && int_sig[RES_BIT] && int_mask[RES_BIT]) begin
         e_req = 1; e_code = 2; nxt = 1;
      end
      if (rst) begin e_req = 0; e_code = 0; e_line = 0; end
      e_stall = e_dep || e_hst || e_halt;
      e_issue = id_valid && !e_stall && !flush && !e_req;
      check_eq("stall", 32'(stall), 32'(e_stall));
      check_eq("issue", 32'(issue), 32'(e_issue));
      check_eq("hilo_busy", 32'(hilo_busy), 32'(e_hbusy));
      check_eq("branch_delay", 32'(branch_delay), 32'(m_bd));
      check_eq("ex_req", 32'(ex_req), 32'(e_req));
      check_eq("ex_code", 32'(ex_code), e_code);
      check_eq("ex_line", 32'(ex_line), e_line);
      check_eq("halted", 32'(halted), 32'(e_halt));
      o_stall = stall; o_issue = issue; o_hbusy = hilo_busy; o_req = ex_req;
      o_halt = halted; o_code = 32'(ex_code); o_line = 32'(ex_line);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (flush) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            hilo_ready = 0;
         end else begin
            if (e_issue && id_rd_we && id_rdc != 0) begin
               lat = (id_lat == 2'd1) ? LD_LAT : (id_lat == 2'd2) ? C0_LAT : 1;
               ready_at[id_rdc] = cyc + lat;
            end
            if (e_issue && id_hilo_we) hilo_ready = cyc + MUL_LAT;
         end
         m_bd    = e_issue && id_jump && !flush;
         m_state = nxt;
      end
      cyc++;
      #1;
   endtask

   // Counts stall cycles before the held instruction issues; bounded at 20.
   task automatic run_until_issue(output int unsigned n);
      logic done;
      n = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         if (o_issue) done = 1;
         else n++;
      end
   endtask

   task automatic settle();
      idle();
      for (int k = 0; k < 8; k++) step();
   endtask

   int unsigned n;

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      idle(); rst = 1; model_reset();
      id_valid = 1; cp0_ie = 1; int_mask = '1; int_sig = 8'h08;
      @(posedge clk); #1;
      step();
      check_eq("rst_ex_req", 32'(o_req), 0);
      rst = 0; idle();
      step();
      check_eq("rst_hilo", 32'(o_hbusy), 0);

      // LW r8 then reader of r8: one bubble
      id_valid = 1; id_rdc = 5'd8; id_rd_we = 1; id_lat = 2'd1; step();
      idle(); id_valid = 1; id_rsc = 5'd8; id_rs_rd = 1;
      run_until_issue(n); check_eq("lw_bubbles", n, 1);
      settle();

      // MFC0 r9 then rt reader: two bubbles; same with r0: none
      id_valid = 1; id_rdc = 5'd9; id_rd_we = 1; id_lat = 2'd2; step();
      idle(); id_valid = 1; id_rtc = 5'd9; id_rt_rd = 1;
      run_until_issue(n); check_eq("mfc0_bubbles", n, 2);
      settle();
      id_valid = 1; id_rdc = 5'd0; id_rd_we = 1; id_lat = 2'd2; step();
      idle(); id_valid = 1; id_rtc = 5'd0; id_rt_rd = 1;
      run_until_issue(n); check_eq("r0_bubbles", n, 0);
      settle();

      // LW r8, short writer of r8, reader of r8: no stall
      id_valid = 1; id_rdc = 5'd8; id_rd_we = 1; id_lat = 2'd1; step();
      id_lat = 2'd0; step();
      idle(); id_valid = 1; id_rsc = 5'd8; id_rs_rd = 1;
      run_until_issue(n); check_eq("short_override", n, 0);
      settle();

      // MULT then MFLO: three bubbles; then flush in the second stall cycle
      id_valid = 1; id_hilo_we = 1; step();
      idle(); id_valid = 1; id_hilo_rd = 1;
      run_until_issue(n); check_eq("mult_bubbles", n, 3);
      settle();
      id_valid = 1; id_hilo_we = 1; step();
      idle(); id_valid = 1; id_hilo_rd = 1; step();
      flush = 1; step();
      flush = 0; step();
      check_eq("flush_hilo_busy", 32'(o_hbusy), 0);
      check_eq("flush_issue", 32'(o_issue), 1);
      settle();

      // Halt, resume, eret
      id_valid = 1; cp0_ie = 1; int_mask = 8'hFF; int_sig = 8'h80; step();
      check_eq("halt_req", 32'(o_req), 1);
      check_eq("halt_code", o_code, 1);
      int_sig = 8'h00; step();
      check_eq("halted", 32'(o_halt), 1);
      check_eq("halt_stall", 32'(o_stall), 1);
      int_sig = 8'h40; step();
      check_eq("res_code", o_code, 2);
      int_sig = 8'h00; step();
      check_eq("svc_not_halted", 32'(o_halt), 0);
      eret = 1; step();
      eret = 0; step();

      // Lowest masked line, then silence until eret
      int_sig = 8'h0A; int_mask = 8'h08; step();
      check_eq("int_req", 32'(o_req), 1);
      check_eq("int_line", o_line, 3);
      check_eq("int_code", o_code, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("svc_quiet", 32'(o_req), 0);
      end
      int_sig = 8'h00; eret = 1; step();
      settle();

      // Randomized traffic
      for (int k = 0; k < 2000; k++) begin
         rst        = ($urandom_range(0, 99) == 0);
         id_valid   = ($urandom_range(0, 3) != 0);
         id_rsc     = 5'($urandom_range(0, 7));
         id_rtc     = 5'($urandom_range(0, 7));
         id_rdc     = 5'($urandom_range(0, 7));
         id_rs_rd   = ($urandom_range(0, 1) == 1);
         id_rt_rd   = ($urandom_range(0, 1) == 1);
         id_rd_we   = ($urandom_range(0, 1) == 1);
         id_lat     = 2'($urandom_range(0, 3));
         id_hilo_rd = ($urandom_range(0, 7) == 0);
         id_hilo_we = ($urandom_range(0, 7) == 0);
         id_jump    = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 15) == 0);
         eret       = ($urandom_range(0, 7) == 0);
         cp0_ie     = ($urandom_range(0, 3) != 0);
         cp0_exl    = ($urandom_range(0, 3) == 0);
         int_mask   = 8'($urandom);
         for (int b = 0; b < NINT; b++) int_sig[b] = ($urandom_range(0, 15) == 0);
         step();
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
